// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states, constants.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    CALC  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_e;

  // LO result of a divide by zero
  localparam logic [MDU_WIDTH-1:0] DIV0_LO = '1;

  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/result bundle between the core (master) and the multiply/divide unit (slave).
interface mdu_seq_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hilo_we, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hilo_we, hi_out, lo_out
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used for operand abs values and result sign fixups.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle, result + HI/LO write strobe
// WIDTH+2 edges after the start edge; cancel aborts anywhere before DONE.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  mdu_seq_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             r_state;
  op_e                r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_dvs;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_b_zero;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_sgn;
  logic               w_div;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_sgn   = op_is_signed(r_op);
  assign w_div   = op_is_div(r_op);
  assign w_neg_a = w_sgn & r_a[WIDTH-1];
  assign w_neg_b = w_sgn & r_b[WIDTH-1];

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .i_val (r_a),
    .i_neg (w_neg_a),
    .o_val (w_a_abs)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .i_val (r_b),
    .i_neg (w_neg_b),
    .o_val (w_b_abs)
  );

  mdu_sign_fix #(.WIDTH(2*WIDTH)) u_prod_fix (
    .i_val (r_acc),
    .i_neg (r_neg_q),
    .o_val (w_prod_fix)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_quo_fix (
    .i_val (r_acc[WIDTH-1:0]),
    .i_neg (r_neg_q),
    .o_val (w_quo_fix)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
    .i_val (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg (r_neg_r),
    .o_val (w_rem_fix)
  );

  // r_acc holds {upper, lower}: {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_dvs};
    w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff    = w_trial - {1'b0, r_dvs};
    w_acc_nxt = r_acc;
    if (w_div) begin
      if (!w_diff[WIDTH]) begin
        w_acc_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end else if (r_acc[0]) begin
      w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    end else begin
      w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_MULTU;
      r_a      <= '0;
      r_b      <= '0;
      r_dvs    <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            r_op    <= op_e'(bus.op);
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_busy  <= 1'b1;
            r_state <= PREP;
          end
        end
        PREP: begin
          if (bus.cancel) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_acc    <= {{WIDTH{1'b0}}, w_a_abs};
            r_dvs    <= w_b_abs;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_b_zero <= (r_b == '0);
            r_cnt    <= '0;
            r_state  <= CALC;
          end
        end
        CALC: begin
          if (bus.cancel) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_state <= FIXUP;
            end
          end
        end
        FIXUP: begin
          if (bus.cancel) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            if (!w_div) begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end else if (r_b_zero) begin
              r_hi <= r_a;
              r_lo <= {WIDTH{DIV0_LO[0]}};
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // cancel is deliberately ignored here so the HI/LO write always lands
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.hilo_we = r_done;
  assign bus.hi_out  = r_hi;
  assign bus.lo_out  = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: cycle-level reference model plus hand-computed literal results.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdu_seq_if #(.WIDTH(W)) bus();

  mdu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference results from plain arithmetic; {hi, lo}
  function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      2'b00: res = {32'd0, a} * {32'd0, b};
      2'b01: res = sa * sb;
      2'b10: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // m_e: edges elapsed since the accepting edge, -1 when idle; result appears at m_e == LAT
  int          m_e = -1;
  logic [63:0] m_pend = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e  <= -1;
      m_hi <= '0;
      m_lo <= '0;
    end else if (m_e < 0) begin
      if (bus.start && !bus.cancel) begin
        m_e    <= 0;
        m_pend <= model_res(bus.op, bus.a, bus.b);
      end
    end else if (m_e == LAT) begin
      m_e <= -1;
    end else if (bus.cancel) begin
      m_e <= -1;
    end else begin
      m_e <= m_e + 1;
      if (m_e == LAT - 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy",    64'(bus.busy),    64'(m_e >= 0));
      check("done",    64'(bus.done),    64'(m_e == LAT));
      check("hilo_we", 64'(bus.hilo_we), 64'(m_e == LAT));
      check("hi_out",  64'(bus.hi_out),  64'(m_hi));
      check("lo_out",  64'(bus.lo_out),  64'(m_lo));
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check({nm, "_reached_done"}, 64'(seen), 64'd1);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge clk);
    start_op(op, a, b);
    wait_done(nm, n);
    check({nm, "_latency"}, 64'(n), 64'(LAT));
    check({nm, "_we"},      64'(bus.hilo_we), 64'd1);
    check({nm, "_hi"},      64'(bus.hi_out), 64'(ehi));
    check({nm, "_lo"},      64'(bus.lo_out), 64'(elo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = 2'b00;
    bus.a      = '0;
    bus.b      = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_we",   64'(bus.hilo_we), 64'd0);
    check("rst_hi",   64'(bus.hi_out), 64'd0);
    check("rst_lo",   64'(bus.lo_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",      OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
    run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_0",    OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
    run_op("div_rneg",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);

    // start while busy at CALC count 5 must be dropped
    @(negedge clk);
    start_op(OP_MULTU, 32'd6, 32'd7);
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore_start", n);
    check("ignore_start_hi", 64'(bus.hi_out), 64'd0);
    check("ignore_start_lo", 64'(bus.lo_out), 64'd42);

    // cancel at CALC count 10, then restart the very next cycle
    @(negedge clk);
    start_op(OP_DIVU, 32'd1000, 32'd3);
    repeat (11) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    check("cancel_done", 64'(bus.done), 64'd0);
    check("cancel_hi",   64'(bus.hi_out), 64'd0);
    check("cancel_lo",   64'(bus.lo_out), 64'd42);
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_done("restart", n);
    check("restart_latency", 64'(n), 64'(LAT));
    check("restart_hi", 64'(bus.hi_out), 64'd2);
    check("restart_lo", 64'(bus.lo_out), 64'd14);

    // cancel with start in IDLE: nothing accepted
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("start_cancel_busy", 64'(bus.busy), 64'd0);

    // asynchronous reset between edges mid-CALC
    @(negedge clk);
    start_op(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_we",   64'(bus.hilo_we), 64'd0);
    check("arst_hi",   64'(bus.hi_out), 64'd0);
    check("arst_lo",   64'(bus.lo_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
